scan_mux: RTL
=============

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL take parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 The block SHALL take parameter W, default 1: bits per channel, legal range 1..32.
REQ-003 The block SHALL take parameter DWELL, default 4: cycles per channel in scan mode, legal range 1..255.
REQ-004 Localparam SW SHALL be max(1, clog2(N)): select width.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port i, input, N*W bits: packed channel data; channel k is i[k*W +: W].
REQ-008 Port s, input, SW bits: manual channel select.
REQ-009 Port mode, input, 1 bit: 0 = manual, 1 = auto-scan.
REQ-010 Port en, input, 1 bit: block enable.
REQ-011 Port y, output, W bits: registered selected data.
REQ-012 Port ch, output, SW bits: channel index that y was sampled from.
REQ-013 Port valid, output, 1 bit: y/ch hold a valid sample.
REQ-014 Port wrap, output, 1 bit: one-cycle pulse when the scan index wraps from N-1 to 0.
REQ-015 Port err, output, 1 bit: manual select was out of range (s >= N) on the last sample.

Function
REQ-016 The FSM SHALL have states IDLE, MAN and SCAN, and SHALL be encoded in a registered state vector.
REQ-017 From any state, en=0 SHALL go to IDLE; en=1 with mode=0 SHALL go to MAN; en=1 with mode=1 SHALL go to SCAN.
REQ-018 In IDLE, y, ch and err SHALL hold their values, valid SHALL be 0 and wrap SHALL be 0.
REQ-019 In MAN with s < N, the block SHALL register y = channel s, ch = s, valid = 1 and err = 0 (latency: 1 cycle from s/i change to y).
REQ-020 In MAN with s >= N (only possible when N is not a power of two), y and ch SHALL hold, valid SHALL be 0 and err SHALL be 1.
REQ-021 In SCAN, the block SHALL keep an internal index idx (SW bits) and a dwell counter dcnt (8 bits).
REQ-022 Each SCAN cycle SHALL register y = channel idx, ch = idx, valid = 1 and err = 0.
REQ-023 Each SCAN cycle, dcnt SHALL increment; when dcnt reaches DWELL-1, dcnt SHALL clear to 0 and idx SHALL advance.
REQ-024 idx SHALL advance as idx+1, except that at N-1 it SHALL go to 0, never to values >= N.
REQ-025 wrap SHALL be 1 for exactly the cycle in which y first presents channel 0 after channel N-1.
REQ-026 On entry to SCAN from IDLE or MAN, idx and dcnt SHALL clear to 0 and the first SCAN output SHALL be channel 0, with no wrap pulse.
REQ-027 With DWELL = 1, idx SHALL advance every cycle.
REQ-028 Leaving SCAN SHALL freeze idx/dcnt, but re-entry SHALL still restart at channel 0 per REQ-026.
REQ-029 Changes on i during a dwell SHALL appear on y one cycle later, because the selected channel is resampled every cycle.
REQ-030 mode changes while en=1 SHALL take effect on the next rising edge, with no idle cycle inserted.

Reset
REQ-031 Asserting rst SHALL immediately set state = IDLE, y = 0, ch = 0, valid = 0, wrap = 0, err = 0, idx = 0 and dcnt = 0, regardless of clk.
REQ-032 After rst deasserts, the first rising edge SHALL evaluate transitions per REQ-017.
REQ-033 rst asserted mid-scan SHALL abort the dwell, and the next SCAN entry SHALL start at channel 0.

Verification
REQ-034 Manual: N=4, W=1, en=1, mode=0, i=4'b1010, s sweeps 00..11 one per cycle -> y = 0,1,0,1 each one cycle after s, with valid=1 and ch=s.
REQ-035 Scan: N=4, DWELL=2, i=4'b1100, en=1, mode=1 -> y = 0,0,0,0,1,1,1,1 repeating, ch = 0,0,1,1,2,2,3,3, and wrap=1 on every 9th, 17th, ... output.
REQ-036 Out-of-range: N=3, mode=0, s=2'b11 -> err=1, valid=0, y holds its prior value; then s=2'b01 -> err=0, valid=1, y = channel 1.
REQ-037 Reset mid-scan: N=4, DWELL=3, assert rst between clock edges at idx=2 -> y, ch and valid are 0 immediately; after release, the first output is channel 0.
REQ-038 Enable/mode toggle: en 1->0 for 3 cycles during MAN -> valid=0 with y held; then mode=1 -> scan starts at ch=0 with no wrap pulse.
REQ-039 Wide data: N=8, W=8, DWELL=1, channel k = 8'hA0+k -> y = A0..A7 on consecutive cycles, wrap=1 with A0 on the second pass.

Source files
------------

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and auto-scan modes.
// Auto-scan dwells DWELL cycles per channel and pulses wrap on return to channel 0.
module scan_mux #(
   parameter  int N     = 4,
   parameter  int W     = 1,
   parameter  int DWELL = 4,
   localparam int SW    = ($clog2(N) > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N*W-1:0] i,
   input  logic [SW-1:0]  s,
   input  logic           mode,
   input  logic           en,
   output logic [W-1:0]   y,
   output logic [SW-1:0]  ch,
   output logic           valid,
   output logic           wrap,
   output logic           err
);

   typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

   localparam logic [7:0]    DLAST = 8'(DWELL - 1);
   localparam logic [SW-1:0] ILAST = SW'(N - 1);

   state_t        r_state, w_state_next;
   logic [W-1:0]  r_y, w_y_next;
   logic [SW-1:0] r_ch, w_ch_next;
   logic          r_valid, w_valid_next;
   logic          r_wrap, w_wrap_next;
   logic          r_err, w_err_next;
   logic [SW-1:0] r_idx, w_idx_next;
   logic [7:0]    r_dcnt, w_dcnt_next;

   logic [W-1:0]  w_chan [N];
   logic [SW-1:0] w_scan_idx;
   logic [7:0]    w_scan_dcnt;
   logic          w_s_ok;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_chan
         assign w_chan[gi] = i[gi*W +: W];
      end
   endgenerate

   // Entering SCAN from another state always starts from channel 0, dwell 0.
   assign w_scan_idx  = (r_state == SCAN) ? r_idx  : '0;
   assign w_scan_dcnt = (r_state == SCAN) ? r_dcnt : '0;
   assign w_s_ok      = (int'(s) < N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_y     <= '0;
         r_ch    <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_dcnt  <= '0;
      end else begin
         r_state <= w_state_next;
         r_y     <= w_y_next;
         r_ch    <= w_ch_next;
         r_valid <= w_valid_next;
         r_wrap  <= w_wrap_next;
         r_err   <= w_err_next;
         r_idx   <= w_idx_next;
         r_dcnt  <= w_dcnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_y_next     = r_y;
      w_ch_next    = r_ch;
      w_valid_next = 1'b0;
      w_wrap_next  = 1'b0;
      w_err_next   = r_err;
      w_idx_next   = r_idx;
      w_dcnt_next  = r_dcnt;

      if (!en) begin
         w_state_next = IDLE;
      end else if (!mode) begin
         w_state_next = MAN;
         if (w_s_ok) begin
            w_y_next     = w_chan[s];
            w_ch_next    = s;
            w_valid_next = 1'b1;
            w_err_next   = 1'b0;
         end else begin
            w_err_next   = 1'b1;
         end
      end else begin
         w_state_next = SCAN;
         w_y_next     = w_chan[w_scan_idx];
         w_ch_next    = w_scan_idx;
         w_valid_next = 1'b1;
         w_err_next   = 1'b0;
         // Channel 0 at dwell 0 while already scanning can only follow channel N-1.
         w_wrap_next  = (r_state == SCAN) && (w_scan_idx == '0) && (w_scan_dcnt == '0);
         if (w_scan_dcnt == DLAST) begin
            w_dcnt_next = '0;
            w_idx_next  = (w_scan_idx == ILAST) ? '0 : w_scan_idx + SW'(1);
         end else begin
            w_dcnt_next = w_scan_dcnt + 8'd1;
            w_idx_next  = w_scan_idx;
         end
      end
   end

   assign y     = r_y;
   assign ch    = r_ch;
   assign valid = r_valid;
   assign wrap  = r_wrap;
   assign err   = r_err;

endmodule
